tuner_verdict_filter: RTL and testbench

Post-processing stage downstream of the max-frequency detector. Consumes each per-frame detection (note number plus low/in-tune/high verdict, qualified by a one-cycle `done` strobe), requires a verdict to repeat on consecutive frames before accepting it, and then holds the accepted result stable for a minimum display time. It replaces the ad-hoc hold counter in the top level and drives the VGA/mouse display's `lowhigh` and note inputs with a debounced, timed-out result.

---
 rtl/tuner_verdict_filter_pkg.sv | 23 ++
 rtl/tuner_verdict_filter_streak_counter.sv | 64 ++++++
 rtl/tuner_verdict_filter.sv | 147 ++++++++++++++
 tb/tb_tuner_verdict_filter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tuner_verdict_filter_pkg.sv
// Shared definitions for the tuner post-processing path.
// Contents: note and verdict types, verdict encodings, the default display hold time
// and the verdict filter FSM state type.
package tuner_verdict_filter_pkg;

  typedef logic [5:0] note_t;
  typedef logic [1:0] pitch_t;

  localparam pitch_t PITCH_INTUNE = 2'b00;
  localparam pitch_t PITCH_FLAT   = 2'b01;
  localparam pitch_t PITCH_SHARP  = 2'b10;
  localparam pitch_t PITCH_NONE   = 2'b11;

  // About 1/6 s at 50 MHz.
  localparam int unsigned DEFAULT_HOLD_CYCLES = 8333334;

  typedef enum logic [1:0] {
    StEmpty,
    StHold,
    StOpen
  } filter_state_e;

endpackage

// File: rtl/tuner_verdict_filter_streak_counter.sv
// Candidate register plus saturating match counter for the verdict filter.
// Ports:
//   clk, resetn        : clock, asynchronous active-low reset
//   clear              : synchronous clear of candidate and streak (overrides done)
//   done               : detection strobe qualifying note_in/pitch_in
//   note_in, pitch_in  : detection fields
//   confirmed          : this done brings (or keeps) the streak at CONFIRM
module tuner_verdict_filter_streak_counter
  import tuner_verdict_filter_pkg::*;
#(
  parameter int unsigned CONFIRM = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       done,
  input  logic [5:0] note_in,
  input  logic [1:0] pitch_in,
  output logic       confirmed
);

  localparam int unsigned StreakW = $clog2(CONFIRM) + 1;
  localparam logic [StreakW-1:0] StreakMax = StreakW'(CONFIRM);

  note_t               cand_note_q, cand_note_d;
  pitch_t              cand_pitch_q, cand_pitch_d;
  logic [StreakW-1:0]  streak_q, streak_d;

  always_comb begin
    cand_note_d  = cand_note_q;
    cand_pitch_d = cand_pitch_q;
    streak_d     = streak_q;
    if (clear || (done && (pitch_in == PITCH_NONE))) begin
      // An empty candidate carries PITCH_NONE, so no real detection can match it.
      cand_note_d  = '0;
      cand_pitch_d = PITCH_NONE;
      streak_d     = '0;
    end else if (done) begin
      if ((note_in == cand_note_q) && (pitch_in == cand_pitch_q)) begin
        streak_d = (streak_q == StreakMax) ? streak_q : streak_q + StreakW'(1);
      end else begin
        cand_note_d  = note_in;
        cand_pitch_d = pitch_in;
        streak_d     = StreakW'(1);
      end
    end
  end

  // Stays asserted on every further identical done once saturated.
  assign confirmed = done && (streak_d == StreakMax);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cand_note_q  <= '0;
      cand_pitch_q <= PITCH_NONE;
      streak_q     <= '0;
    end else begin
      cand_note_q  <= cand_note_d;
      cand_pitch_q <= cand_pitch_d;
      streak_q     <= streak_d;
    end
  end

endmodule

// File: rtl/tuner_verdict_filter.sv
// Debounces and times out per-frame tuner detections before they reach the display.
// A detection must repeat CONFIRM times in a row to be accepted; an accepted result
// stays on the outputs for at least HOLD_CYCLES; TIMEOUT_CYCLES without any done
// reverts to no-signal; a change of the target note flushes everything.
// Ports:
//   clk, resetn          : clock (CLOCK_50), asynchronous active-low reset
//   done                 : one-cycle strobe qualifying note_in/pitch_in
//   note_in, pitch_in    : detected note and verdict
//   expected             : user-selected target note
//   note_out, pitch_out  : accepted note and verdict
//   valid                : an accepted result is displayed
//   holding              : hold timer running
//   update               : one-cycle pulse when note_out/pitch_out change
module tuner_verdict_filter
  import tuner_verdict_filter_pkg::*;
#(
  parameter int unsigned CONFIRM        = 3,
  parameter int unsigned HOLD_CYCLES    = DEFAULT_HOLD_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       done,
  input  logic [5:0] note_in,
  input  logic [1:0] pitch_in,
  input  logic [5:0] expected,
  output logic [5:0] note_out,
  output logic [1:0] pitch_out,
  output logic       valid,
  output logic       holding,
  output logic       update
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES) + 1;
  localparam int unsigned SilW  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [SilW-1:0]  SilLast  = SilW'(TIMEOUT_CYCLES - 1);

  filter_state_e     state_q, state_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [SilW-1:0]   sil_q, sil_d;
  note_t             note_q, note_d;
  pitch_t            pitch_q, pitch_d;
  logic              update_q, update_d;
  note_t             expected_q;

  logic exp_change;
  logic timeout;
  logic clear;
  logic confirmed;

  assign exp_change = (expected != expected_q);
  // A done in the expiry cycle wins and restarts the silence count.
  assign timeout    = (state_q != StEmpty) && !done && (sil_q == SilLast);
  assign clear      = exp_change || timeout;

  tuner_verdict_filter_streak_counter #(
    .CONFIRM (CONFIRM)
  ) u_streak (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (clear),
    .done      (done),
    .note_in   (note_in),
    .pitch_in  (pitch_in),
    .confirmed (confirmed)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    sil_d    = sil_q;
    note_d   = note_q;
    pitch_d  = pitch_q;
    update_d = 1'b0;

    if (clear) begin
      state_d  = StEmpty;
      hold_d   = '0;
      sil_d    = '0;
      note_d   = '0;
      pitch_d  = PITCH_NONE;
      // Leaving EMPTY-to-EMPTY on a target change is not an output change.
      update_d = (state_q != StEmpty);
    end else begin
      sil_d = done ? '0 : sil_q + SilW'(1);
      unique case (state_q)
        StEmpty: begin
          sil_d = '0;
          if (confirmed) begin
            note_d   = note_in;
            pitch_d  = pitch_in;
            update_d = 1'b1;
            hold_d   = '0;
            state_d  = StHold;
          end
        end
        StHold: begin
          // Confirmations here only build the streak; they are never loaded.
          if (hold_q == HoldLast) begin
            hold_d  = '0;
            state_d = StOpen;
          end else begin
            hold_d = hold_q + HoldW'(1);
          end
        end
        StOpen: begin
          if (confirmed && ((note_in != note_q) || (pitch_in != pitch_q))) begin
            note_d   = note_in;
            pitch_d  = pitch_in;
            update_d = 1'b1;
            hold_d   = '0;
            state_d  = StHold;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StEmpty;
      hold_q     <= '0;
      sil_q      <= '0;
      note_q     <= '0;
      pitch_q    <= PITCH_NONE;
      update_q   <= 1'b0;
      expected_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      sil_q      <= sil_d;
      note_q     <= note_d;
      pitch_q    <= pitch_d;
      update_q   <= update_d;
      expected_q <= expected;
    end
  end

  assign note_out  = note_q;
  assign pitch_out = pitch_q;
  assign valid     = (state_q != StEmpty);
  assign holding   = (state_q == StHold);
  assign update    = update_q;

endmodule

// File: tb/tb_tuner_verdict_filter.sv
// Scoreboard bench for tuner_verdict_filter. The driver steps a behavioural model
// (detection history queue, load/last-done timestamps) and queues the expected
// per-cycle outputs and the expected payload of each update pulse; an independent
// monitor pops and compares on every falling edge.
module tb_tuner_verdict_filter;

  localparam int CONFIRM = 3;
  localparam int HOLD    = 20;
  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       done = 1'b0;
  logic [5:0] note_in = '0;
  logic [1:0] pitch_in = '0;
  logic [5:0] expected = 6'd9;
  logic [5:0] note_out;
  logic [1:0] pitch_out;
  logic       valid;
  logic       holding;
  logic       update;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic       valid;
    logic       holding;
    logic       update;
    logic [5:0] note;
    logic [1:0] pitch;
  } snap_t;

  typedef struct packed {
    logic [5:0] note;
    logic [1:0] pitch;
    logic       valid;
  } ev_t;

  snap_t snap_q[$];
  ev_t   ev_q[$];

  // Reference model state.
  logic [7:0] hist[$];
  logic       m_valid = 1'b0;
  logic       m_upd = 1'b0;
  logic [5:0] m_note = '0;
  logic [1:0] m_pitch = 2'b11;
  logic [5:0] exp_reg = '0;
  logic [5:0] exp_val = 6'd9;
  int         cyc = 0;
  int         load_cyc = 0;
  int         last_done = 0;

  tuner_verdict_filter #(
    .CONFIRM        (CONFIRM),
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .done      (done),
    .note_in   (note_in),
    .pitch_in  (pitch_in),
    .expected  (expected),
    .note_out  (note_out),
    .pitch_out (pitch_out),
    .valid     (valid),
    .holding   (holding),
    .update    (update)
  );

  always #5 clk = ~clk;

  task automatic m_emit_clear();
    m_valid = 1'b0;
    m_note  = '0;
    m_pitch = 2'b11;
    m_upd   = 1'b1;
    ev_q.push_back(ev_t'{6'd0, 2'b11, 1'b0});
  endtask

  task automatic m_load(input logic [5:0] n, input logic [1:0] p);
    m_valid  = 1'b1;
    m_note   = n;
    m_pitch  = p;
    m_upd    = 1'b1;
    load_cyc = cyc;
    ev_q.push_back(ev_t'{n, p, 1'b1});
  endtask

  // One cycle of the reference: a result is accepted once the last CONFIRM
  // detections are identical; it may be replaced only after HOLD display cycles.
  task automatic m_step(input logic d, input logic [5:0] n, input logic [1:0] p);
    logic [7:0] pair;
    pair = {n, p};
    if (exp_val != exp_reg) begin
      exp_reg = exp_val;
      hist.delete();
      if (m_valid) m_emit_clear();
    end else if (m_valid && !d && ((cyc - last_done) == TIMEOUT)) begin
      hist.delete();
      m_emit_clear();
    end else if (d) begin
      last_done = cyc;
      if (p == 2'b11) begin
        hist.delete();
      end else begin
        if ((hist.size() > 0) && (hist[$] != pair)) hist.delete();
        hist.push_back(pair);
        if (hist.size() >= CONFIRM) begin
          if (!m_valid) m_load(n, p);
          else if ((cyc > load_cyc + HOLD) && (pair != {m_note, m_pitch})) m_load(n, p);
        end
      end
    end
  endtask

  task automatic tick(input logic d, input logic [5:0] n, input logic [1:0] p);
    @(posedge clk);
    #1;
    done     = d;
    note_in  = n;
    pitch_in = p;
    expected = exp_val;
    snap_q.push_back(snap_t'{m_valid, m_valid && (cyc <= load_cyc + HOLD), m_upd,
                             m_note, m_pitch});
    m_upd = 1'b0;
    m_step(d, n, p);
    cyc++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, 6'd0, 2'b00);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    done = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    n_vec++;
    if ({note_out, pitch_out, valid, holding, update} != {6'd0, 2'b11, 3'b000}) begin
      n_err++;
      $display("FAIL async-reset: got note=%0d pitch=%b v=%0b h=%0b u=%0b, want 0 11 0 0 0",
               note_out, pitch_out, valid, holding, update);
    end
    @(posedge clk);
    #2;
    resetn = 1'b1;
    hist.delete();
    m_valid = 1'b0;
    m_note  = '0;
    m_pitch = 2'b11;
    m_upd   = 1'b0;
    exp_reg = '0;
    cyc++;
    // The cycle right after release is unsampled but still seen by the DUT.
    m_step(1'b0, 6'd0, 2'b00);
    cyc++;
  endtask

  // Monitor.
  always @(negedge clk) begin
    snap_t s;
    ev_t   e;
    if (resetn && (snap_q.size() > 0)) begin
      s = snap_q.pop_front();
      n_vec++;
      if ({valid, holding, update, note_out, pitch_out} != s) begin
        n_err++;
        $display("FAIL state t=%0t: got v=%0b h=%0b u=%0b note=%0d pitch=%b, want v=%0b h=%0b u=%0b note=%0d pitch=%b",
                 $time, valid, holding, update, note_out, pitch_out,
                 s.valid, s.holding, s.update, s.note, s.pitch);
      end
    end
    if (resetn && update) begin
      n_vec++;
      if (ev_q.size() == 0) begin
        n_err++;
        $display("FAIL update-event t=%0t: got unexpected update note=%0d pitch=%b v=%0b, want none",
                 $time, note_out, pitch_out, valid);
      end else begin
        e = ev_q.pop_front();
        if ({note_out, pitch_out, valid} != e) begin
          n_err++;
          $display("FAIL update-event t=%0t: got note=%0d pitch=%b v=%0b, want note=%0d pitch=%b v=%0b",
                   $time, note_out, pitch_out, valid, e.note, e.pitch, e.valid);
        end
      end
    end
  end

  initial begin
    int r;
    logic [5:0] rn;
    logic [1:0] rp;
    #22 resetn = 1'b1;
    idle(3);

    // Three flat note-9 detections, five cycles apart; then out of hold.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 6'd9, 2'b01);
      idle(4);
    end
    idle(25);
    idle(110);  // silence timeout

    // flat, flat, sharp, flat, flat: never three in a row.
    tick(1'b1, 6'd4, 2'b01); idle(2);
    tick(1'b1, 6'd4, 2'b01); idle(2);
    tick(1'b1, 6'd4, 2'b10); idle(2);
    tick(1'b1, 6'd4, 2'b01); idle(2);
    tick(1'b1, 6'd4, 2'b01); idle(5);
    tick(1'b1, 6'd4, 2'b01);  // third in a row -> load

    // Confirmed sharp during hold is not loaded; next one after hold is.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 6'd9, 2'b10);
      idle(2);
    end
    idle(15);
    tick(1'b1, 6'd9, 2'b10);

    // Done exactly on the 100th silent cycle prevents the timeout.
    idle(99);
    tick(1'b1, 6'd9, 2'b10);
    idle(100);
    idle(5);

    // Target change together with the confirming done.
    for (int i = 0; i < 3; i++) tick(1'b1, 6'd9, 2'b01);
    idle(25);
    tick(1'b1, 6'd9, 2'b10);
    tick(1'b1, 6'd9, 2'b10);
    exp_val = 6'd11;
    tick(1'b1, 6'd9, 2'b10);
    idle(5);

    // Reset mid-hold; the streak must rebuild from zero.
    for (int i = 0; i < 3; i++) tick(1'b1, 6'd11, 2'b00);
    idle(5);
    pulse_reset();
    tick(1'b1, 6'd11, 2'b00);
    tick(1'b1, 6'd11, 2'b00);
    idle(3);
    tick(1'b1, 6'd11, 2'b00);
    idle(25);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 35) begin
        rn = ($urandom_range(0, 1) == 0) ? 6'd9 : 6'd10;
        rp = 2'($urandom_range(0, 3));
        tick(1'b1, rn, rp);
      end else if (r == 98) begin
        idle(105);
      end else if (r == 99) begin
        exp_val = (exp_val == 6'd9) ? 6'd11 : 6'd9;
        tick(1'b0, 6'd0, 2'b00);
      end else begin
        tick(1'b0, 6'd0, 2'b00);
      end
    end
    idle(3);
    @(posedge clk);
    #1;

    n_vec++;
    if (ev_q.size() != 0) begin
      n_err++;
      $display("FAIL pending-updates: got %0d update pulses missing, want 0", ev_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
